perip_bus_master: RTL and testbench
===================================

# perip_bus_master

Single-outstanding bus initiator that drives the peripheral request/handshake bus (`req`/`we`/`addr`/`data`/`wem` out; `addr_ok`/`data_ok`/rdata back) used by the GPIO, timer and UART responders. It accepts one load/store at a time from the core memory stage over a valid/ready port and runs the two-phase handshake: address phase, then data phase. It returns read data, or an error flag when the optional watchdog fires. It sits between the core LSU path and the peripheral address decoder.

## Interface
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles, counted from first `req_o` assertion; legal range 2..255.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req_i` in 1: core request valid.
- `cpu_ready_o` out 1: master idle; a request is accepted when `cpu_req_i & cpu_ready_o`.
- `cpu_we_i` in 1: 1 = write, 0 = read.
- `cpu_addr_i` in 32: byte address.
- `cpu_wdata_i` in 32: write data.
- `cpu_wem_i` in `` `RAM_MASK_WIDTH ``: byte-lane write mask.
- `cpu_rdata_o` out 32: read data; valid with `cpu_rvalid_o`.
- `cpu_rvalid_o` out 1: one-cycle completion pulse, for reads and writes.
- `cpu_err_o` out 1: completion was a timeout; qualified by `cpu_rvalid_o`.
- `req_o` out 1: bus request.
- `we_o` out 1: bus write enable.
- `addr_o` out 32: bus address.
- `data_o` out 32: bus write data.
- `wem_o` out `` `RAM_MASK_WIDTH ``: bus byte mask.
- `addr_ok_i` in 1: responder accepted the address phase.
- `data_ok_i` in 1: responder data phase complete.
- `data_i` in 32: responder read data, sampled when `data_ok_i` is high.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `cpu_ready_o` = 1.
  - On accept, register `we`/`addr`/`wdata`/`wem` into the bus output registers and go to REQ.
- REQ:
  - `req_o` = 1; `we_o`, `addr_o`, `data_o` and `wem_o` are held stable.
  - On `addr_ok_i`:
    - If `data_ok_i` is high in the same cycle, capture data and go to RESP.
    - Otherwise go to WAIT.
- WAIT:
  - `req_o` = 0; address and data outputs are held.
  - On `data_ok_i`, capture and go to RESP.
- RESP:
  - `cpu_rvalid_o` = 1 for exactly one cycle, then return to IDLE.
- Captured read data:
  - Reads: `cpu_rdata_o` = `data_i` at capture.
  - Writes: `cpu_rdata_o` = 0.
- `cpu_rdata_o` holds its value until the next completion.
- `data_ok_i` and `addr_ok_i` are ignored in IDLE and RESP. Stale `data_ok` from a previous transaction never completes a new one.
- `cpu_req_i` is ignored while `cpu_ready_o` = 0. There is no queueing.

## Timing
- Reset values: all outputs 0, except `cpu_ready_o` = 1; FSM = IDLE; timeout counter = 0.
- Reset is asynchronous at any point, including mid-transaction. `req_o` drops immediately and the in-flight transaction is discarded with no `cpu_rvalid_o`.
- Nominal sequence with a responder whose `addr_ok` is combinational and whose `data_ok` is registered:
  - Cycle 0: accept.
  - Cycle 1: `req_o` = 1 and `addr_ok_i` = 1.
  - Cycle 2: `data_ok_i` = 1.
  - Cycle 3: `cpu_rvalid_o` = 1.
  - Cycle 4: `cpu_ready_o` = 1.
- Load-to-use latency: 3 cycles. Peak throughput: 1 transaction per 4 cycles.
- Zero-wait responder (`addr_ok` and `data_ok` in the same cycle): `cpu_rvalid_o` in cycle 2.
- `req_o` is deasserted the cycle after `addr_ok_i`. It is never high in two consecutive transactions without passing through RESP and IDLE.

## Configuration
- `PERIP_BUS_TIMEOUT_EN` defined:
  - An 8-bit counter increments each cycle in REQ or WAIT and clears in IDLE.
  - When it reaches `TIMEOUT_CYCLES`: force `req_o` = 0, go to RESP with `cpu_err_o` = 1 and `cpu_rdata_o` = 0.
  - A `data_ok_i` arriving in that same cycle takes priority, giving a normal completion with `cpu_err_o` = 0.
- `PERIP_BUS_TIMEOUT_EN` undefined:
  - No counter; REQ and WAIT wait indefinitely.
  - `cpu_err_o` is tied to 0.

## Structure
- The shared defines file holds:
  - `RAM_MASK_WIDTH`.
  - The FSM state encoding as localparams `PBM_IDLE`/`PBM_REQ`/`PBM_WAIT`/`PBM_RESP` (2 bits).
  - The default `TIMEOUT_CYCLES`.
- One sub-module, `perip_bus_wdt`: the timeout counter with `clr`/`en`/`expired`. It is instantiated only under `PERIP_BUS_TIMEOUT_EN`.

## Test plan
- Write 0x0000_0055 to addr 0x4 of a GPIO responder → `req_o` high for 1 cycle, `we_o` = 1, `wem_o` = cpu mask; `cpu_rvalid_o` at cycle 3 with `cpu_rdata_o` = 0; GPIO data register = 0x55.
- Read addr 0x0 after writing ctrl = 0x0000_000A → `cpu_rdata_o` = 0x0000_000A with `cpu_rvalid_o` at cycle 3; `cpu_ready_o` low in cycles 1–3.
- Responder delays `addr_ok` 5 cycles, then `data_ok` 3 cycles later → `req_o` high exactly 6 cycles; outputs stable throughout; single `cpu_rvalid_o`.
- Zero-wait responder (`addr_ok` = `data_ok` = 1 in the REQ cycle) → completion at cycle 2; `data_ok_i` held high through the next transaction's REQ cycle does not complete it early.
- With `PERIP_BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, a responder that never answers → `cpu_rvalid_o` = 1 and `cpu_err_o` = 1 after 8 cycles of `req_o`; the next request proceeds normally.
- Assert `rst_n` = 0 in WAIT → asynchronously `req_o` = 0 and `cpu_ready_o` = 1; no `cpu_rvalid_o` after release.

Source files
------------

// File: rtl/perip_bus_master_pkg.sv
// Shared types and constants for the peripheral bus initiator.
// Optional watchdog is enabled by defining PERIP_BUS_TIMEOUT_EN.
`ifndef RAM_MASK_WIDTH
`define RAM_MASK_WIDTH 4
`endif

package perip_bus_master_pkg;

  localparam logic [1:0] PBM_IDLE = 2'd0;
  localparam logic [1:0] PBM_REQ  = 2'd1;
  localparam logic [1:0] PBM_WAIT = 2'd2;
  localparam logic [1:0] PBM_RESP = 2'd3;

  localparam int PBM_TIMEOUT_DEFAULT = 255;
  localparam int PBM_CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = PBM_IDLE,
    S_REQ  = PBM_REQ,
    S_WAIT = PBM_WAIT,
    S_RESP = PBM_RESP
  } pbm_state_e;

endpackage

// File: rtl/perip_bus_master_wdt.sv
// Bus transaction watchdog: counts busy cycles, flags the limit cycle.
// Instantiated only when PERIP_BUS_TIMEOUT_EN is defined.
module perip_bus_wdt
  import perip_bus_master_pkg::*;
#(
  parameter int LIMIT = PBM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [PBM_CNT_W-1:0] r_cnt;
  logic                 w_hit;

  // Flag during the LIMIT-th busy cycle so the bus drops after LIMIT cycles
  assign w_hit     = (r_cnt == PBM_CNT_W'(LIMIT - 1));
  assign o_expired = i_en & w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_hit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/perip_bus_master.sv
// Single-outstanding two-phase peripheral bus initiator.
// Optional watchdog is enabled by defining PERIP_BUS_TIMEOUT_EN.
`ifndef RAM_MASK_WIDTH
`define RAM_MASK_WIDTH 4
`endif

module perip_bus_master
  import perip_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PBM_TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_req_i,
  output logic                       cpu_ready_o,
  input  logic                       cpu_we_i,
  input  logic [31:0]                cpu_addr_i,
  input  logic [31:0]                cpu_wdata_i,
  input  logic [`RAM_MASK_WIDTH-1:0] cpu_wem_i,
  output logic [31:0]                cpu_rdata_o,
  output logic                       cpu_rvalid_o,
  output logic                       cpu_err_o,
  output logic                       req_o,
  output logic                       we_o,
  output logic [31:0]                addr_o,
  output logic [31:0]                data_o,
  output logic [`RAM_MASK_WIDTH-1:0] wem_o,
  input  logic                       addr_ok_i,
  input  logic                       data_ok_i,
  input  logic [31:0]                data_i
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("perip_bus_master: TIMEOUT_CYCLES outside 2..255");
  end

  pbm_state_e r_state;
  pbm_state_e w_next;
  logic       w_accept;
  logic       w_capture;
  logic       w_tmo;
  logic       w_expired;

  logic                       r_we;
  logic [31:0]                r_addr;
  logic [31:0]                r_data;
  logic [`RAM_MASK_WIDTH-1:0] r_wem;
  logic [31:0]                r_rdata;

`ifdef PERIP_BUS_TIMEOUT_EN
  logic w_wdt_clr;
  logic w_wdt_en;
  logic r_err;

  assign w_wdt_clr = (r_state == S_IDLE);
  assign w_wdt_en  = (r_state == S_REQ) | (r_state == S_WAIT);

  perip_bus_wdt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_wdt_clr),
    .i_en     (w_wdt_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_capture) begin
      r_err <= 1'b0;
    end else if (w_tmo) begin
      r_err <= 1'b1;
    end
  end

  assign cpu_err_o = r_err;
`else
  assign w_expired = 1'b0;
  assign cpu_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // data_ok only counts once the address phase is accepted
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_tmo     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cpu_req_i) begin
          w_accept = 1'b1;
          w_next   = S_REQ;
        end
      end
      S_REQ: begin
        if (addr_ok_i && data_ok_i) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end else if (w_expired) begin
          w_tmo  = 1'b1;
          w_next = S_RESP;
        end else if (addr_ok_i) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_ok_i) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end else if (w_expired) begin
          w_tmo  = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wem   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we   <= cpu_we_i;
        r_addr <= cpu_addr_i;
        r_data <= cpu_wdata_i;
        r_wem  <= cpu_wem_i;
      end
      if (w_capture) begin
        r_rdata <= r_we ? 32'h0 : data_i;
      end else if (w_tmo) begin
        r_rdata <= 32'h0;
      end
    end
  end

  assign cpu_ready_o  = (r_state == S_IDLE);
  assign cpu_rvalid_o = (r_state == S_RESP);
  assign req_o        = (r_state == S_REQ);
  assign we_o         = r_we;
  assign addr_o       = r_addr;
  assign data_o       = r_data;
  assign wem_o        = r_wem;
  assign cpu_rdata_o  = r_rdata;

endmodule

// File: tb/tb_perip_bus_master.sv
// Scoreboard bench for perip_bus_master with a GPIO-like responder.
// Timeout cases run when PERIP_BUS_TIMEOUT_EN is defined.
`ifndef RAM_MASK_WIDTH
`define RAM_MASK_WIDTH 4
`endif

module tb_perip_bus_master;

`ifdef PERIP_BUS_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_i;
  logic        cpu_ready_o;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [`RAM_MASK_WIDTH-1:0] cpu_wem_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_rvalid_o;
  logic        cpu_err_o;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [`RAM_MASK_WIDTH-1:0] wem_o;
  logic        addr_ok_i;
  logic        data_ok_i;
  logic [31:0] data_i;

  always #5 clk = ~clk;

  perip_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_ready_o(cpu_ready_o),
    .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_wem_i(cpu_wem_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o),
    .cpu_err_o(cpu_err_o), .req_o(req_o), .we_o(we_o),
    .addr_o(addr_o), .data_o(data_o), .wem_o(wem_o),
    .addr_ok_i(addr_ok_i), .data_ok_i(data_ok_i), .data_i(data_i)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // responder: two 32-bit registers, ctrl at 0x0, data at 0x4
  int   a_dly = 0;
  int   d_dly = 1;
  bit   zw    = 1'b0;
  bit   never = 1'b0;
  bit   stick = 1'b0;
  logic [31:0] rsp_mem [2];
  int   req_cyc;
  int   wcnt;
  bit   pend;
  logic dok_base;

  always_comb begin
    addr_ok_i = 1'b0;
    dok_base  = 1'b0;
    addr_ok_i = req_o && !never && (req_cyc >= a_dly);
    dok_base  = zw ? addr_ok_i : (pend && (wcnt == d_dly - 1));
    data_ok_i = dok_base | stick;
    data_i    = rsp_mem[addr_o[2]];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_mem[0] <= '0;
      rsp_mem[1] <= '0;
      req_cyc    <= 0;
      wcnt       <= 0;
      pend       <= 1'b0;
    end else begin
      req_cyc <= (req_o && !addr_ok_i) ? req_cyc + 1 : 0;
      if (req_o && addr_ok_i) begin
        if (we_o) begin
          for (int b = 0; b < 4; b++)
            if (wem_o[b])
              rsp_mem[addr_o[2]][8*b +: 8] <= data_o[8*b +: 8];
        end
        pend <= !zw;
        wcnt <= 0;
      end else if (pend) begin
        if (dok_base) pend <= 1'b0;
        else          wcnt <= wcnt + 1;
      end
    end
  end

  logic [32:0] sb_q [$];

  always @(negedge clk) begin
    if (rst_n && cpu_rvalid_o) begin
      if (sb_q.size() == 0) begin
        expect_eq("sb_unexpected_rvalid", 32'(sb_q.size()), 32'd1);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        expect_eq("sb_rdata", cpu_rdata_o, e[31:0]);
        expect_eq("sb_err", {31'd0, cpu_err_o}, {31'd0, e[32]});
      end
    end
  end

  task automatic txn(input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] m,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_lat, input int exp_reqc);
    int guard = 0;
    int cyc   = 0;
    int reqc  = 0;
    int hold_bad = 0;
    int rdy_bad  = 0;
    while (!cpu_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = a;
    cpu_wdata_i = wd;
    cpu_wem_i   = m;
    sb_q.push_back({exp_err, exp_rd});
    @(posedge clk);
    #1;
    cpu_req_i   = 1'b0;
    cpu_we_i    = ~we;
    cpu_addr_i  = ~a;
    cpu_wdata_i = ~wd;
    cpu_wem_i   = ~m;
    do begin
      @(negedge clk);
      cyc++;
      reqc += int'(req_o);
      if (cyc == 1) begin
        expect_eq("bus_we", {31'd0, we_o}, {31'd0, we});
        expect_eq("bus_wem", {28'd0, wem_o}, {28'd0, m});
      end
      if (!cpu_rvalid_o && (addr_o !== a || data_o !== wd)) hold_bad++;
      if (cpu_ready_o) rdy_bad++;
    end while (!cpu_rvalid_o && cyc < 400);
    expect_eq("latency", cyc, exp_lat);
    expect_eq("req_cycles", reqc, exp_reqc);
    expect_eq("bus_hold", hold_bad, 0);
    expect_eq("ready_low", rdy_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int rv;
    rst_n       = 1'b0;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    cpu_wem_i   = '0;
    #1;
    expect_eq("rst_ready", {31'd0, cpu_ready_o}, 32'd1);
    expect_eq("rst_req", {31'd0, req_o}, 32'd0);
    expect_eq("rst_rvalid", {31'd0, cpu_rvalid_o}, 32'd0);
    expect_eq("rst_rdata", cpu_rdata_o, 32'd0);
    expect_eq("rst_addr", addr_o, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // nominal write / write / read
    txn(1'b1, 32'h4, 32'h55, 4'h1, 32'h0, 1'b0, 3, 1);
    expect_eq("gpio_data", rsp_mem[1], 32'h55);
    txn(1'b1, 32'h0, 32'hA, 4'hF, 32'h0, 1'b0, 3, 1);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 32'hA, 1'b0, 3, 1);

    // slow responder: addr_ok after 5 cycles, data_ok 3 later
    a_dly = 5;
    d_dly = 3;
`ifdef PERIP_BUS_TIMEOUT_EN
    txn(1'b0, 32'h4, 32'h0, 4'h0, 32'h0, 1'b1, 9, 6);
`else
    txn(1'b0, 32'h4, 32'h0, 4'h0, 32'h55, 1'b0, 10, 6);
`endif

    // zero-wait responder, partial mask write
    a_dly = 0;
    d_dly = 1;
    zw    = 1'b1;
    txn(1'b1, 32'h0, 32'h1234_5678, 4'hC, 32'h0, 1'b0, 2, 1);
    expect_eq("gpio_ctrl_mask", rsp_mem[0], 32'h1234_000A);

    // stale data_ok held into the next REQ must not complete it
    zw    = 1'b0;
    a_dly = 3;
    @(negedge clk);
    stick = 1'b1;
    fork
      begin
        repeat (2) @(negedge clk);
        stick = 1'b0;
      end
    join_none
    txn(1'b0, 32'h0, 32'h0, 4'h0, 32'h1234_000A, 1'b0, 6, 4);

`ifdef PERIP_BUS_TIMEOUT_EN
    a_dly = 0;
    never = 1'b1;
    txn(1'b0, 32'h4, 32'h0, 4'h0, 32'h0, 1'b1, 9, 8);
    never = 1'b0;
    txn(1'b0, 32'h4, 32'h0, 4'h0, 32'h55, 1'b0, 3, 1);
`endif

    // async reset in WAIT discards the transaction
    a_dly = 0;
    d_dly = 20;
    @(negedge clk);
    while (!cpu_ready_o) @(negedge clk);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h4;
    @(posedge clk);
    #1;
    cpu_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_eq("pre_rst_wait", {31'd0, req_o | cpu_ready_o}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_eq("arst_req", {31'd0, req_o}, 32'd0);
    expect_eq("arst_ready", {31'd0, cpu_ready_o}, 32'd1);
    expect_eq("arst_addr", addr_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rv = 0;
    repeat (30) begin
      @(negedge clk);
      rv += int'(cpu_rvalid_o);
    end
    expect_eq("no_rvalid_after_rst", rv, 0);

    d_dly = 1;
    txn(1'b0, 32'h4, 32'h0, 4'h0, 32'h0, 1'b0, 3, 1);
    repeat (2) @(negedge clk);
    expect_eq("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
